uart_byte_tx: RTL and testbench

Serial transmit end of the command-response link. Accepts one byte at a time from the string parser's response_data/response_flag handshake and serialises it as an 8N1 UART frame, LSB first, on txd. Bit timing comes from the shared 16x oversampling enable clken_16bps. Returns tx_done to the parser, which uses it to advance to the next response character.

---
 rtl/uart_byte_tx.sv | 182 ++++++++++++++++++
 tb/tb_uart_byte_tx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: serialises one byte per txd_flag handshake as an 8N1 UART frame, LSB first,
// paced by the 16x enable clken_16bps. Define UART_TX_PARITY_EN to add an even parity bit.
module uart_byte_tx #(
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clken_16bps,
    input  logic [7:0] txd_data,
    input  logic       txd_flag,
    output logic       txd,
    output logic       tx_done,
    output logic       txd_busy
);

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] DATA_LAST = 3'd7;
    // Anything other than 2 stop bits collapses to a single stop bit.
    localparam logic [2:0] STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        REARM  = 3'd5
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4,
        REARM = 3'd5
    } state_t;
`endif

    state_t     state_r;
    logic [3:0] tick_cnt_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic       txd_r;
    logic       tx_done_r;
    logic       txd_busy_r;
    logic       bit_end_s;
    logic       tick_hold_s;
`ifdef UART_TX_PARITY_EN
    logic       parity_r;
`endif

    // Decode the end of the current bit period and whether the tick counter is parked.
    always_comb begin
        bit_end_s   = 1'b0;
        tick_hold_s = 1'b0;
        if (clken_16bps && (tick_cnt_r == TICK_LAST)) begin
            bit_end_s = 1'b1;
        end else begin
            bit_end_s = 1'b0;
        end
        if ((state_r == IDLE) || (state_r == REARM)) begin
            tick_hold_s = 1'b1;
        end else begin
            tick_hold_s = 1'b0;
        end
    end

    // Oversampling tick counter; parked at zero outside a frame so each frame starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_r <= 4'd0;
        end else if (tick_hold_s) begin
            tick_cnt_r <= 4'd0;
        end else if (bit_end_s) begin
            tick_cnt_r <= 4'd0;
        end else if (clken_16bps) begin
            tick_cnt_r <= tick_cnt_r + 4'd1;
        end else begin
            tick_cnt_r <= tick_cnt_r;
        end
    end

    // Frame sequencer; txd takes each new bit on the edge that enters its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'd0;
            txd_r      <= 1'b1;
            tx_done_r  <= 1'b0;
            txd_busy_r <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            tx_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (txd_flag) begin
                        shift_r    <= txd_data;
`ifdef UART_TX_PARITY_EN
                        parity_r   <= even_parity(txd_data);
`endif
                        bit_cnt_r  <= 3'd0;
                        txd_r      <= 1'b0;
                        txd_busy_r <= 1'b1;
                        state_r    <= START;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        txd_r     <= shift_r[0];
                        bit_cnt_r <= 3'd0;
                        state_r   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        shift_r <= {1'b0, shift_r[7:1]};
                        if (bit_cnt_r == DATA_LAST) begin
                            bit_cnt_r <= 3'd0;
`ifdef UART_TX_PARITY_EN
                            txd_r     <= parity_r;
                            state_r   <= PARITY;
`else
                            txd_r     <= 1'b1;
                            state_r   <= STOP;
`endif
                        end else begin
                            txd_r     <= shift_r[1];
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end_s) begin
                        txd_r     <= 1'b1;
                        bit_cnt_r <= 3'd0;
                        state_r   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end_s) begin
                        if (bit_cnt_r == STOP_LAST) begin
                            bit_cnt_r  <= 3'd0;
                            tx_done_r  <= 1'b1;
                            txd_busy_r <= 1'b0;
                            state_r    <= REARM;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end
                end
                // The parser still holds its flag right after tx_done; wait for it to drop.
                REARM: begin
                    if (!txd_flag) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    bit_cnt_r  <= 3'd0;
                    txd_r      <= 1'b1;
                    txd_busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign txd      = txd_r;
    assign tx_done  = tx_done_r;
    assign txd_busy = txd_busy_r;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx: directed sequence with random bytes and enable rates,
// checked by an oversampling UART receiver model that decodes txd independently of the RTL.
module tb_uart_byte_tx;

    localparam int OS  = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FB  = 11;
`else
    localparam int FB  = 10;
`endif
    localparam int TMO = 3000;

    logic       clk;
    logic       rst;
    logic       clken_16bps;
    logic [7:0] txd_data;
    logic       txd_flag;
    logic       txd;
    logic       tx_done;
    logic       txd_busy;

    int checks = 0;
    int errors = 0;

    uart_byte_tx dut (
        .clk        (clk),
        .rst        (rst),
        .clken_16bps(clken_16bps),
        .txd_data   (txd_data),
        .txd_flag   (txd_flag),
        .txd        (txd),
        .tx_done    (tx_done),
        .txd_busy   (txd_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Enable generator: one pulse every div clocks (div=1 holds the enable high).
    int div = 4;
    int ph  = 0;
    initial begin
        clken_16bps = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph = ph + 1;
            if (ph >= div) ph = 0;
            clken_16bps = (ph == 0);
        end
    end

    // Receiver model state, owned by the monitor process.
    logic [11:0] frame_q[$];
    logic [11:0] rx_bits;
    bit          rx_active  = 1'b0;
    bit          len_active = 1'b0;
    bit          chk_idle   = 1'b0;
    bit          prev_en    = 1'b0;
    bit          prev_done  = 1'b0;
    bit          en_edge;
    int          rx_idx     = 0;
    int          len_cnt    = 0;
    int          start_cyc  = 0;
    int          last_lat   = 0;
    int          done_cnt   = 0;
    int          done_viol  = 0;
    int          len_viol   = 0;
    int          busy_viol  = 0;
    int          idle_viol  = 0;

    initial begin
        forever begin
            @(negedge clk);
            en_edge = prev_en;
            prev_en = clken_16bps;
            if (rst) begin
                rx_active  = 1'b0;
                len_active = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (chk_idle && (txd !== 1'b1 || tx_done !== 1'b0 || txd_busy !== 1'b0)) idle_viol++;
                if (len_active && en_edge) begin
                    len_cnt++;
                    if (rx_active && (len_cnt == OS / 2 + OS * rx_idx)) begin
                        rx_bits[rx_idx] = txd;
                        rx_idx++;
                        if (rx_idx == FB) begin
                            rx_active = 1'b0;
                            frame_q.push_back(rx_bits);
                        end
                    end
                end
                if (tx_done === 1'b1) begin
                    done_cnt++;
                    if (prev_done) done_viol++;
                    if (!len_active || len_cnt != OS * FB) len_viol++;
                    if (txd_busy !== 1'b0) busy_viol++;
                    last_lat   = cyc - start_cyc;
                    len_active = 1'b0;
                end else if (len_active && txd_busy !== 1'b1) begin
                    busy_viol++;
                end
                if (!len_active && !rx_active && txd === 1'b0) begin
                    len_active = 1'b1;
                    rx_active  = 1'b1;
                    len_cnt    = 0;
                    rx_idx     = 0;
                    rx_bits    = '0;
                    start_cyc  = cyc;
                    if (txd_busy !== 1'b1) busy_viol++;
                end
                prev_done = (tx_done === 1'b1);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: observed no finish, required finish before %0d cycles", cyc);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [11:0] last_frame;

    task automatic check_frame(input string tag, input logic [7:0] b);
        logic [11:0] expv;
        expv = '0;
`ifdef UART_TX_PARITY_EN
        expv[10:0] = {1'b1, ^b, b, 1'b0};
`else
        expv[9:0]  = {1'b1, b, 1'b0};
`endif
        check({tag, "_present"}, 32'(frame_q.size() != 0), 32'd1);
        if (frame_q.size() != 0) begin
            last_frame = frame_q.pop_front();
            check(tag, 32'(last_frame), 32'(expv));
        end
    endtask

    // Parser-style request: raise the flag with the byte and hold it until tx_done.
    task automatic send(input logic [7:0] b, input bit scramble, input bit drop);
        int t;
        @(posedge clk);
        #2;
        txd_data = b;
        txd_flag = 1'b1;
        @(posedge clk);
        #2;
        if (scramble) txd_data = 8'($urandom);
        if (drop) begin
            repeat (40) @(posedge clk);
            #2;
            txd_flag = 1'b0;
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (tx_done !== 1'b1 && t < TMO);
        check("tx_done_seen", 32'(tx_done), 32'd1);
    endtask

    task automatic release_flag(input int hold);
        repeat (hold) @(posedge clk);
        @(posedge clk);
        #2;
        txd_flag = 1'b0;
    endtask

    initial begin
        string s;
        int    t;
        int    d0;
        logic [7:0] b;
        rst      = 1'b1;
        txd_flag = 1'b0;
        txd_data = 8'h00;

        // Reset values and quiet idle line
        #1;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        check("rst_busy", 32'(txd_busy), 32'd0);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        div = 3;
        chk_idle = 1'b1;
        repeat (1000) @(posedge clk);
        #2;
        chk_idle = 1'b0;
        check("idle_quiet", 32'(idle_viol), 32'd0);
        check("idle_no_done", 32'(done_cnt), 32'd0);

        // Single byte 0x66 at one enable per 4 clk
        div = 4;
        d0 = done_cnt;
        send(8'h66, 1'b0, 1'b0);
        // Hold the flag after tx_done: REARM must not start another frame
        release_flag(50);
        check("hold_busy_low", 32'(txd_busy), 32'd0);
        check("hold_txd_idle", 32'(txd), 32'd1);
        check("hold_one_done", 32'(done_cnt - d0), 32'd1);
        check("hold_no_frame", 32'(len_active), 32'd0);
        check("latency_66", 32'(last_lat >= 4 * OS * FB - 3 && last_lat <= 4 * OS * FB), 32'd1);
        check_frame("frame_66", 8'h66);
`ifndef UART_TX_PARITY_EN
        check("frame_66_bits", 32'(last_frame[9:0]), 32'(10'b1011001100));
`endif
        send(8'h6E, 1'b0, 1'b0);
        release_flag(0);
        check_frame("frame_6e", 8'h6E);
`ifndef UART_TX_PARITY_EN
        check("frame_6e_bits", 32'(last_frame[9:0]), 32'(10'b1011011100));
`endif

        // Response string with the fastest parser handshake and random enable rates
        s  = "filter_already_on";
        d0 = done_cnt;
        for (int i = 0; i < s.len(); i++) begin
            div = $urandom_range(1, 5);
            send(s[i], 1'b0, 1'b0);
            release_flag(0);
            check_frame("string_char", s[i]);
        end
        check("string_done_count", 32'(done_cnt - d0), 32'd17);

        // Random bytes; data changes after accept and early flag drops must not matter
        for (int i = 0; i < 8; i++) begin
            div = $urandom_range(1, 5);
            b   = 8'($urandom);
            send(b, 1'b1, 1'($urandom_range(0, 1)));
            release_flag(0);
            check_frame("random_byte", b);
        end

        // Reset during data bit 3 of 0x55
        div = 4;
        @(posedge clk);
        #2;
        txd_data = 8'h55;
        txd_flag = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (rx_idx != 5 && t < TMO);
        check("reached_bit3", 32'(rx_idx), 32'd5);
        check("bit3_level", 32'(txd), 32'd0);
        d0  = done_cnt;
        rst = 1'b1;
        #1;
        check("midrst_txd_async", 32'(txd), 32'd1);
        check("midrst_busy_async", 32'(txd_busy), 32'd0);
        txd_flag = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (600) @(posedge clk);
        #2;
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        check("midrst_no_frame", 32'(frame_q.size()), 32'd0);
        send(8'hA5, 1'b0, 1'b0);
        release_flag(0);
        check_frame("frame_a5", 8'hA5);

`ifdef UART_TX_PARITY_EN
        // Even parity bit sits between data bit 7 and the stop bit
        div = 2;
        send(8'h66, 1'b0, 1'b0);
        release_flag(0);
        check_frame("parity_frame_66", 8'h66);
        check("parity_bit_66", 32'(last_frame[9]), 32'd0);
        send(8'h67, 1'b0, 1'b0);
        release_flag(0);
        check_frame("parity_frame_67", 8'h67);
        check("parity_bit_67", 32'(last_frame[9]), 32'd1);
`endif

        repeat (5) @(posedge clk);
        #2;
        check("frame_lengths", 32'(len_viol), 32'd0);
        check("busy_coverage", 32'(busy_viol), 32'd0);
        check("done_single_pulse", 32'(done_viol), 32'd0);
        check("frames_all_consumed", 32'(frame_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
